// File: rtl/chacha_xor_sequencer.sv
// ChaCha20 keystream sequencer: requests 64-byte blocks and XORs them with streaming plaintext.
// Latency: one cycle from plaintext accept to ciphertext valid; plaintext stalls while the output register is blocked or a block is outstanding.
module chacha_xor_sequencer #(
  parameter int DATA_SIZE   = 8,
  parameter int BLOCK_BYTES = 64,
  parameter int CTR_WIDTH   = 32,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [CTR_WIDTH-1:0]             init_ctr,
  input  logic [LEN_WIDTH-1:0]             msg_len,
  output logic                             ks_req,
  output logic [CTR_WIDTH-1:0]             ks_ctr,
  input  logic                             ks_ack,
  input  logic [BLOCK_BYTES*DATA_SIZE-1:0] ks_block,
  input  logic                             pt_valid,
  output logic                             pt_ready,
  input  logic [DATA_SIZE-1:0]             pt_data,
  output logic                             ct_valid,
  input  logic                             ct_ready,
  output logic [DATA_SIZE-1:0]             ct_data,
  output logic                             ct_last,
  output logic                             busy,
  output logic                             done,
  output logic                             ctr_err
);

  localparam int IDX_W = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XOR   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                           state;
  logic [IDX_W-1:0]                 idx;
  logic [LEN_WIDTH-1:0]             remaining;
  logic [BLOCK_BYTES*DATA_SIZE-1:0] block_q;
  logic [DATA_SIZE-1:0]             ks_byte;
  logic                             pt_fire;
  logic                             ct_fire;
  logic                             last_byte;

  assign ks_req    = (state == REQ);
  assign busy      = (state != IDLE);
  assign pt_ready  = (state == XOR) && (!ct_valid || ct_ready);
  assign pt_fire   = pt_valid && pt_ready;
  assign ct_fire   = ct_valid && ct_ready;
  assign last_byte = (remaining == LEN_WIDTH'(1));
  assign ks_byte   = block_q[int'(idx)*DATA_SIZE +: DATA_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      remaining <= '0;
      block_q   <= '0;
      ks_ctr    <= '0;
      ct_valid  <= 1'b0;
      ct_data   <= '0;
      ct_last   <= 1'b0;
      done      <= 1'b0;
      ctr_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      ctr_err <= 1'b0;

      // The output register drains in every state; a new byte below overrides this.
      if (ct_fire) begin
        ct_valid <= 1'b0;
        ct_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (msg_len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= REQ;
              ks_ctr    <= init_ctr;
              remaining <= msg_len;
              idx       <= '0;
            end
          end
        end

        REQ: begin
          if (ks_ack) begin
            block_q <= ks_block;
            state   <= XOR;
          end
        end

        XOR: begin
          if (pt_fire) begin
            ct_data   <= pt_data ^ ks_byte;
            ct_valid  <= 1'b1;
            ct_last   <= last_byte;
            idx       <= idx + IDX_W'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (last_byte) begin
              state <= FLUSH;
            end else if (idx == LAST_IDX) begin
              // Counter must never wrap: abort rather than reuse keystream.
              if (&ks_ctr) begin
                ctr_err <= 1'b1;
                state   <= IDLE;
              end else begin
                ks_ctr <= ks_ctr + CTR_WIDTH'(1);
                state  <= REQ;
              end
            end
          end
        end

        FLUSH: begin
          if (ct_fire && ct_last) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_xor_sequencer.sv
// Directed bench for chacha_xor_sequencer with a behavioural keystream core and ct monitor.
module tb_chacha_xor_sequencer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [31:0]  init_ctr;
  logic [15:0]  msg_len;
  logic         ks_req;
  logic [31:0]  ks_ctr;
  logic         ks_ack;
  logic [511:0] ks_block;
  logic         pt_valid;
  logic         pt_ready;
  logic [7:0]   pt_data;
  logic         ct_valid;
  logic         ct_ready;
  logic [7:0]   ct_data;
  logic         ct_last;
  logic         busy;
  logic         done;
  logic         ctr_err;

  chacha_xor_sequencer #(
    .DATA_SIZE(8), .BLOCK_BYTES(64), .CTR_WIDTH(32), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_ctr(init_ctr), .msg_len(msg_len),
    .ks_req(ks_req), .ks_ctr(ks_ctr), .ks_ack(ks_ack), .ks_block(ks_block),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .ct_last(ct_last),
    .busy(busy), .done(done), .ctr_err(ctr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Keystream core model: mode 0 -> every byte A5, mode 1 -> every byte = low counter byte.
  int ks_mode = 0;
  int wait_cnt = 0;

  function automatic logic [511:0] make_block(input logic [31:0] ctr);
    logic [511:0] b;
    for (int i = 0; i < 64; i++) b[i*8 +: 8] = (ks_mode == 1) ? ctr[7:0] : 8'hA5;
    return b;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (ks_ack) begin
      ks_ack = 1'b0;
    end else if (ks_req) begin
      if (wait_cnt == 2) begin
        ks_ack   = 1'b1;
        ks_block = make_block(ks_ctr);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  logic [7:0]  ct_q[$];
  bit          last_q[$];
  logic [31:0] req_q[$];
  int  done_cnt = 0, err_cnt = 0, stab_err = 0, stall_cnt = 0;
  int  cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  bit  stalled = 0, prev_req = 0, prev_l = 0;
  logic [7:0] prev_d = 8'h00;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled  = 0;
      prev_req = 0;
    end else begin
      if (stalled && (!ct_valid || ct_data !== prev_d || ct_last !== prev_l)) stab_err++;
      stalled = ct_valid && !ct_ready;
      prev_d  = ct_data;
      prev_l  = ct_last;
      if (stalled) stall_cnt++;
      if (ct_valid && ct_ready) begin
        ct_q.push_back(ct_data);
        last_q.push_back(ct_last);
        if (ct_last) last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ctr_err) err_cnt++;
      if (ks_req && !prev_req) req_q.push_back(ks_ctr);
      prev_req = ks_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ct_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic clear();
    ct_q.delete();
    last_q.delete();
    req_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    stab_err = 0;
    stall_cnt = 0;
  endtask

  task automatic start_msg(input logic [31:0] ctr, input logic [15:0] len);
    init_ctr = ctr;
    msg_len  = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  function automatic logic [7:0] pt_byte(input int kind, input int n);
    case (kind)
      0:       return 8'(n + 1);
      1:       return 8'(n);
      default: return 8'(n * 3 + 1);
    endcase
  endfunction

  // Streams up to n bytes; stops early at stop_at or when the cycle budget runs out.
  task automatic send(input int n, input int stop_at, input bit bp, input int kind, output int sent);
    int  cycles;
    bit  fire;
    cycles   = 0;
    sent     = 0;
    pt_valid = (n > 0);
    pt_data  = pt_byte(kind, 0);
    while (sent < n && sent != stop_at && cycles < n * 6 + 100) begin
      @(negedge clk);
      fire = pt_valid && pt_ready;
      tick();
      if (fire) begin
        sent++;
        pt_data = pt_byte(kind, sent);
      end
      pt_valid = (sent < n) && (sent != stop_at);
      ct_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cycles++;
    end
    pt_valid = 1'b0;
  endtask

  initial begin
    int sent;
    int mism;
    int nlast;
    rst_n    = 1'b0;
    start    = 1'b0;
    init_ctr = '0;
    msg_len  = '0;
    ks_ack   = 1'b0;
    ks_block = '0;
    pt_valid = 1'b0;
    pt_data  = '0;
    ct_ready = 1'b1;

    #3;
    chk("rst_ks_req", longint'(ks_req), 0);
    chk("rst_ct_valid", longint'(ct_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_pt_ready", longint'(pt_ready), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_ct_data", longint'(ct_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 1: short message, single block
    clear();
    ks_mode = 0;
    start_msg(32'd1, 16'd3);
    send(3, -1, 1'b0, 0, sent);
    idle(8);
    chk("t1_sent", sent, 3);
    chk("t1_req_n", req_q.size(), 1);
    chk("t1_req_ctr", longint'(req_q[0]), 1);
    chk("t1_ct_n", ct_q.size(), 3);
    chk("t1_ct0", longint'(ct_q[0]), 'hA4);
    chk("t1_ct1", longint'(ct_q[1]), 'hA7);
    chk("t1_ct2", longint'(ct_q[2]), 'hA6);
    chk("t1_last", longint'({last_q[0], last_q[1], last_q[2]}), 'b001);
    chk("t1_done_n", done_cnt, 1);
    chk("t1_done_lat", done_cyc - last_hs_cyc, 1);
    chk("t1_busy_end", longint'(busy), 0);

    // 2: three blocks, partial final block
    clear();
    ks_mode = 1;
    start_msg(32'd7, 16'd130);
    send(130, -1, 1'b0, 1, sent);
    idle(8);
    chk("t2_req_n", req_q.size(), 3);
    chk("t2_req0", longint'(req_q[0]), 7);
    chk("t2_req1", longint'(req_q[1]), 8);
    chk("t2_req2", longint'(req_q[2]), 9);
    chk("t2_ct_n", ct_q.size(), 130);
    mism = 0;
    nlast = 0;
    for (int i = 0; i < ct_q.size(); i++) begin
      if (ct_q[i] !== (8'(i) ^ 8'(7 + i / 64))) mism++;
      if (last_q[i]) nlast++;
    end
    chk("t2_data_mism", mism, 0);
    chk("t2_ct128", longint'(ct_q[128]), 'h89);
    chk("t2_ct129", longint'(ct_q[129]), 'h88);
    chk("t2_last_pos", longint'(last_q[129]), 1);
    chk("t2_last_n", nlast, 1);
    chk("t2_done_n", done_cnt, 1);

    // 3: random output backpressure
    clear();
    ks_mode = 0;
    start_msg(32'd20, 16'd64);
    send(64, -1, 1'b1, 2, sent);
    idle(12);
    chk("t3_ct_n", ct_q.size(), 64);
    mism = 0;
    for (int i = 0; i < ct_q.size(); i++)
      if (ct_q[i] !== (8'(i * 3 + 1) ^ 8'hA5)) mism++;
    chk("t3_data_mism", mism, 0);
    chk("t3_stable", stab_err, 0);
    chk("t3_stalled", longint'(stall_cnt > 0), 1);
    chk("t3_done_n", done_cnt, 1);
    chk("t3_req_ctr", longint'(req_q[0]), 20);

    // 4: empty message
    clear();
    start_msg(32'd3, 16'd0);
    chk("t4_done", longint'(done), 1);
    chk("t4_busy", longint'(busy), 0);
    chk("t4_ks_req", longint'(ks_req), 0);
    tick();
    chk("t4_done_pulse", longint'(done), 0);
    idle(4);
    chk("t4_req_n", req_q.size(), 0);
    chk("t4_done_n", done_cnt, 1);

    // 5: counter exhaustion at block boundary
    clear();
    start_msg(32'hFFFF_FFFF, 16'd65);
    send(65, -1, 1'b0, 0, sent);
    idle(5);
    chk("t5_sent", sent, 64);
    chk("t5_ct_n", ct_q.size(), 64);
    chk("t5_ctr_err_n", err_cnt, 1);
    chk("t5_req_n", req_q.size(), 1);
    chk("t5_req_ctr", longint'(req_q[0]), 'hFFFF_FFFF);
    chk("t5_done_n", done_cnt, 0);
    chk("t5_busy", longint'(busy), 0);
    chk("t5_ct_valid", longint'(ct_valid), 0);

    // 6: asynchronous reset mid-message, then a fresh message
    clear();
    ks_mode = 1;
    start_msg(32'd3, 16'd40);
    send(40, 20, 1'b0, 1, sent);
    chk("t6_busy_pre", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", longint'(busy), 0);
    chk("t6_ct_valid", longint'(ct_valid), 0);
    chk("t6_pt_ready", longint'(pt_ready), 0);
    chk("t6_ks_ctr", longint'(ks_ctr), 0);
    chk("t6_ct_data", longint'(ct_data), 0);
    repeat (2) tick();
    chk("t6_no_done", done_cnt, 0);
    rst_n = 1'b1;
    tick();
    clear();
    start_msg(32'd5, 16'd4);
    send(4, -1, 1'b0, 0, sent);
    idle(8);
    chk("t6_ct_n", ct_q.size(), 4);
    chk("t6_ct0", longint'(ct_q[0]), 'h04);
    chk("t6_ct3", longint'(ct_q[3]), 'h01);
    chk("t6_req_ctr", longint'(req_q[0]), 5);
    chk("t6_done_n", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
